pc_fetch_unit: RTL
==================

Name: pc_fetch_unit

Overview:
Program-counter and fetch-request stage of the single-cycle RV32 core, directly upstream of the PC adders and instruction memory. It holds the architectural PC and issues fetch requests to imem over a valid/ready handshake. It selects the next PC from sequential (PC+4), branch (PC+offset) or JALR target, and traps on misaligned redirect targets.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
TRAP_PC, 32'h0000_0010, PC loaded on misaligned-target trap
XLEN, 32, datapath width (only 32 is supported)

Ports:
clk  in  1  core clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state
stall  in  1  hazard hold; blocks new requests, never aborts an outstanding one
br_taken  in  1  conditional branch/JAL taken, sampled on fire cycle
br_offset  in  32  signed byte offset, added to the current PC
jalr_taken  in  1  JALR redirect, sampled on fire cycle
jalr_target  in  32  rs1+imm from ALU; bit0 is cleared internally
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  imem accepts the request
imem_addr  out  32  fetch address, equal to pc
pc  out  32  current PC
pc_plus4  out  32  pc+4, for the link register
misalign_trap  out  1  one-cycle pulse on trap entry
bad_addr  out  32  offending target, held until the next trap
fetch_count  out  32  accepted fetches, saturating

Behaviour:
- Handshake: fire = imem_req_valid && imem_req_ready.
- Reset values: state=BOOT, pc=RESET_PC, imem_req_valid=0, misalign_trap=0, bad_addr=0, fetch_count=0. Outputs drop asynchronously on reset assertion, including mid-request; no partial update survives.
- BOOT: one cycle with valid=0, then -> RUN.
- RUN:
  - valid=1 unless stall=1 and no request is outstanding.
  - Once valid rises, it and imem_addr stay stable until fire, regardless of stall.
- HOLD: entered from RUN when stall=1 and nothing is outstanding. Valid=0. Returns to RUN the cycle after stall=0.
- On fire, the next PC is chosen by priority:
  1. jalr_taken: {jalr_target[31:1],1'b0}
  2. br_taken: pc+br_offset
  3. otherwise: pc+4
- All additions are modulo 2^32; pc=32'hFFFF_FFFC with no redirect wraps to 0.
- br_taken and jalr_taken both high: JALR wins.
- Misalignment: a selected redirect target with bit1=1 (after the JALR bit0 clear), or a branch target with [1:0]!=0, triggers a trap:
  - pc <= TRAP_PC, bad_addr <= target, misalign_trap=1 next cycle.
  - State -> TRAP for one cycle with valid=0, then -> RUN.
  - The PC+4 path never traps.
- fetch_count: +1 per fire, saturates at 32'hFFFF_FFFF.
- Redirect inputs are ignored when there is no fire.
- Latency: pc updates the cycle after fire. A new request may issue the following cycle, giving 1 fetch/cycle when ready is tied high.
- Stall with ready low: the request stays pending; the address is unchanged.

Decomposition:
- Package riscv_fetch_pkg:
  - fetch_state_t enum {BOOT, RUN, HOLD, TRAP}
  - INSTR_BYTES=4
  - helper function is_misaligned(addr)
- Sub-module pc_adder (32-bit a+b, combinational), instantiated twice: pc+4 and pc+br_offset.

Test Plan:
1. Reset then ready=1, no redirects -> BOOT one cycle; imem_addr 0,4,8,12 on consecutive cycles; fetch_count=3 after three fires.
2. Ready low for 3 cycles at pc=8 while stall pulses -> valid stays 1, addr stays 8; on ready, pc=12 next cycle.
3. pc=0x100, br_taken, br_offset=-8 -> pc=0xF8. Both br_taken and jalr_taken with jalr_target=0x201 -> pc=0x200.
4. jalr_target=0x302 -> misalign_trap pulses 1 cycle, bad_addr=0x302, pc=TRAP_PC, one valid=0 cycle, then fetch at 0x10.
5. pc=0xFFFF_FFFC, ready=1 -> next pc=0x0, no trap. fetch_count preloaded near max -> saturates at 0xFFFF_FFFF.
6. Assert reset mid-request (valid=1, ready=0, pc=0x40) -> valid=0 immediately, pc=RESET_PC, count=0; BOOT sequence repeats after release.

Source files
------------

// File: rtl/riscv_fetch_pkg.sv
// riscv_fetch_pkg
// Shared types and helpers for the RV32 PC / fetch-request stage.
//   fetch_state_t : fetch sequencer states (BOOT, RUN, HOLD, TRAP)
//   INSTR_BYTES   : size of one instruction, the sequential PC step
//   is_misaligned : true when an address is not on a 4-byte boundary
package riscv_fetch_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    TRAP = 2'd3
  } fetch_state_t;

  localparam logic [31:0] INSTR_BYTES = 32'd4;

  // Instruction targets must be word aligned.
  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/pc_adder.sv
// pc_adder
// Plain 32-bit modulo-2^32 adder used for both PC+4 and PC+branch offset.
// Ports:
//   a, b : operands
//   sum  : a + b, carry out discarded
module pc_adder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
// Holds the architectural PC and issues instruction fetch requests over a
// valid/ready handshake. On every accepted fetch the next PC is chosen from
// JALR target, branch target (PC+offset) or PC+4, in that priority order.
// A misaligned redirect target sends the PC to TRAP_PC and records the
// offending address.
// Ports:
//   clk, reset              : clock, asynchronous active-high reset
//   stall                   : hazard hold, blocks new requests only
//   br_taken, br_offset     : taken branch/JAL and its byte offset
//   jalr_taken, jalr_target : JALR redirect and its rs1+imm target
//   imem_req_valid/ready    : fetch request handshake
//   imem_addr, pc, pc_plus4 : fetch address, current PC, PC+4
//   misalign_trap, bad_addr : trap-entry pulse and offending target
//   fetch_count             : saturating count of accepted fetches
module pc_fetch_unit
  import riscv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] TRAP_PC    = 32'h0000_0010,
  parameter int          XLEN       = 32,            // only 32 is supported
  parameter logic [31:0] COUNT_INIT = 32'h0000_0000  // fetch_count value after reset
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_offset,
  input  logic            jalr_taken,
  input  logic [XLEN-1:0] jalr_target,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            misalign_trap,
  output logic [XLEN-1:0] bad_addr,
  output logic [XLEN-1:0] fetch_count
);

  fetch_state_t state_reg;
  logic [31:0]  pc_reg;
  logic         valid_reg;
  logic         trap_reg;
  logic [31:0]  bad_addr_reg;
  logic [31:0]  count_reg;

  logic [31:0]  seq_target;
  logic [31:0]  br_target;
  logic [31:0]  jalr_aligned;
  logic [31:0]  redirect_target;
  logic [31:0]  pc_next;
  logic         redirect;
  logic         fire;
  logic         take_trap;

  pc_adder u_seq_adder (
    .a   (pc_reg),
    .b   (INSTR_BYTES),
    .sum (seq_target)
  );

  pc_adder u_br_adder (
    .a   (pc_reg),
    .b   (br_offset),
    .sum (br_target)
  );

  always_comb begin
    fire            = valid_reg && imem_req_ready;
    jalr_aligned    = {jalr_target[31:1], 1'b0};
    redirect        = jalr_taken || br_taken;
    redirect_target = jalr_taken ? jalr_aligned : br_target;
    pc_next         = redirect ? redirect_target : seq_target;
    // Only redirects can trap; the sequential path stays aligned by construction.
    take_trap       = redirect && is_misaligned(redirect_target);
  end

  // Valid is asserted only in RUN, so a request once raised cannot be
  // withdrawn by stall; stall is honoured at the fire edge by moving to HOLD.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= BOOT;
      pc_reg       <= RESET_PC;
      valid_reg    <= 1'b0;
      trap_reg     <= 1'b0;
      bad_addr_reg <= 32'h0000_0000;
      count_reg    <= COUNT_INIT;
    end else begin
      trap_reg <= 1'b0;

      if (fire && (count_reg != 32'hFFFF_FFFF)) begin
        count_reg <= count_reg + 32'd1;
      end

      case (state_reg)
        BOOT: begin
          state_reg <= RUN;
          valid_reg <= 1'b1;
        end
        RUN: begin
          if (fire) begin
            if (take_trap) begin
              pc_reg       <= TRAP_PC;
              bad_addr_reg <= redirect_target;
              trap_reg     <= 1'b1;
              state_reg    <= TRAP;
              valid_reg    <= 1'b0;
            end else begin
              pc_reg <= pc_next;
              if (stall) begin
                state_reg <= HOLD;
                valid_reg <= 1'b0;
              end
            end
          end
        end
        HOLD: begin
          if (!stall) begin
            state_reg <= RUN;
            valid_reg <= 1'b1;
          end
        end
        TRAP: begin
          state_reg <= RUN;
          valid_reg <= 1'b1;
        end
        default: begin
          state_reg <= BOOT;
          valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req_valid = valid_reg;
  assign imem_addr      = pc_reg;
  assign pc             = pc_reg;
  assign pc_plus4       = seq_target;
  assign misalign_trap  = trap_reg;
  assign bad_addr       = bad_addr_reg;
  assign fetch_count    = count_reg;

endmodule
